// File: rtl/alu_reservation_station.sv
// ALU reservation station: holds dispatched ops until both operands are present,
// snoops the CDB for wakeups and issues the lowest ready slot to a single ALU.
module alu_reservation_station #(
  parameter int unsigned ENTRIES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        disp_valid,
  output logic        disp_ready,
  input  logic [5:0]  disp_opcode,
  input  logic [4:0]  disp_dest_tag,
  input  logic [4:0]  disp_qj,
  input  logic [4:0]  disp_qk,
  input  logic [31:0] disp_vj,
  input  logic [31:0] disp_vk,
  input  logic        cdb_valid,
  input  logic [4:0]  cdb_tag,
  input  logic [31:0] cdb_data,
  output logic        alu_start,
  output logic [5:0]  alu_opcode,
  output logic [31:0] alu_op1,
  output logic [31:0] alu_op2,
  output logic [4:0]  alu_dest_tag,
  input  logic        alu_done,
  output logic [3:0]  occupancy
);

  localparam int unsigned IDX_W  = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
  localparam int unsigned OP_W   = 6;
  localparam int unsigned TAG_W  = 5;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 4;

  typedef struct packed {
    logic              valid;
    logic [OP_W-1:0]   opcode;
    logic [TAG_W-1:0]  dest;
    logic [TAG_W-1:0]  qj;
    logic [DATA_W-1:0] vj;
    logic [TAG_W-1:0]  qk;
    logic [DATA_W-1:0] vk;
  } slot_t;

  slot_t              slot_q [ENTRIES];
  slot_t              slot_d [ENTRIES];
  slot_t              new_slot;
  logic               busy_q, busy_d;
  logic               start_q, start_d;
  logic [OP_W-1:0]    opcode_q, opcode_d;
  logic [DATA_W-1:0]  op1_q, op1_d;
  logic [DATA_W-1:0]  op2_q, op2_d;
  logic [TAG_W-1:0]   dest_q, dest_d;
  logic [CNT_W-1:0]   occ_q, occ_d;
  logic               ready_q, ready_d;
  logic               issue_found, free_found, issue, disp_fire, cdb_hit;
  logic [IDX_W-1:0]   issue_idx, free_idx;

  // Slot selection, CDB wakeup, dispatch write and issue, all from registered state
  always_comb begin
    issue_found = 1'b0;
    free_found  = 1'b0;
    issue_idx   = '0;
    free_idx    = '0;
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      slot_d[i] = slot_q[i];
      if (!issue_found && slot_q[i].valid && slot_q[i].qj == '0 && slot_q[i].qk == '0) begin
        issue_found = 1'b1;
        issue_idx   = IDX_W'(i);
      end
      if (!free_found && !slot_q[i].valid) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end

    issue     = issue_found && (!busy_q || alu_done);
    disp_fire = disp_valid && ready_q && free_found;
    cdb_hit   = cdb_valid && (cdb_tag != '0);

    for (int unsigned i = 0; i < ENTRIES; i++) begin
      if (slot_q[i].valid && cdb_hit && slot_q[i].qj == cdb_tag) begin
        slot_d[i].vj = cdb_data;
        slot_d[i].qj = '0;
      end
      if (slot_q[i].valid && cdb_hit && slot_q[i].qk == cdb_tag) begin
        slot_d[i].vk = cdb_data;
        slot_d[i].qk = '0;
      end
    end

    // Incoming operands may be satisfied by the broadcast in the same cycle
    new_slot.valid  = 1'b1;
    new_slot.opcode = disp_opcode;
    new_slot.dest   = disp_dest_tag;
    new_slot.qj     = disp_qj;
    new_slot.vj     = disp_vj;
    new_slot.qk     = disp_qk;
    new_slot.vk     = disp_vk;
    if (cdb_hit && disp_qj == cdb_tag) begin
      new_slot.qj = '0;
      new_slot.vj = cdb_data;
    end
    if (cdb_hit && disp_qk == cdb_tag) begin
      new_slot.qk = '0;
      new_slot.vk = cdb_data;
    end

    start_d  = 1'b0;
    opcode_d = opcode_q;
    op1_d    = op1_q;
    op2_d    = op2_q;
    dest_d   = dest_q;
    if (issue) begin
      slot_d[issue_idx].valid = 1'b0;
      start_d  = 1'b1;
      opcode_d = slot_q[issue_idx].opcode;
      op1_d    = slot_q[issue_idx].vj;
      op2_d    = slot_q[issue_idx].vk;
      dest_d   = slot_q[issue_idx].dest;
    end
    if (disp_fire) begin
      slot_d[free_idx] = new_slot;
    end

    if (issue) begin
      busy_d = 1'b1;
    end else if (alu_done) begin
      busy_d = 1'b0;
    end else begin
      busy_d = busy_q;
    end

    occ_d   = occ_q + CNT_W'(disp_fire) - CNT_W'(issue);
    ready_d = occ_d < CNT_W'(ENTRIES);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        slot_q[i] <= '0;
      end
      busy_q   <= 1'b0;
      start_q  <= 1'b0;
      opcode_q <= '0;
      op1_q    <= '0;
      op2_q    <= '0;
      dest_q   <= '0;
      occ_q    <= '0;
      ready_q  <= 1'b1;
    end else begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        slot_q[i] <= slot_d[i];
      end
      busy_q   <= busy_d;
      start_q  <= start_d;
      opcode_q <= opcode_d;
      op1_q    <= op1_d;
      op2_q    <= op2_d;
      dest_q   <= dest_d;
      occ_q    <= occ_d;
      ready_q  <= ready_d;
    end
  end

  assign disp_ready   = ready_q;
  assign alu_start    = start_q;
  assign alu_opcode   = opcode_q;
  assign alu_op1      = op1_q;
  assign alu_op2      = op2_q;
  assign alu_dest_tag = dest_q;
  assign occupancy    = occ_q;

endmodule

// File: doc/alu_reservation_station.md
ALU_RESERVATION_STATION -- requirements
Module: alu_reservation_station

Interface
REQ-001 SHALL have parameter ENTRIES, default 4, number of station slots (2..8).
REQ-002 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports disp_valid  input  1  and disp_ready  output  1  dispatch handshake; transfer when both high.
REQ-005 SHALL have ports disp_opcode  input  6, disp_dest_tag  input  5, result tag of dispatched instruction.
REQ-006 SHALL have ports disp_qj, disp_qk  input  5  producer tags; 5'd0 means operand present in disp_vj/disp_vk (input 32 each).
REQ-007 SHALL have ports cdb_valid  input  1, cdb_tag  input  5, cdb_data  input  32  result broadcast snooped by all slots.
REQ-008 SHALL have ports alu_start  output  1, alu_opcode  output  6, alu_op1, alu_op2  output  32, alu_dest_tag  output  5  issue to ALU.
REQ-009 SHALL have port alu_done  input  1  ALU completion pulse, one per accepted start.
REQ-010 SHALL have port occupancy  output  4  number of valid slots.

Function
REQ-011 Slot state SHALL be: valid, opcode, dest_tag, qj, vj, qk, vk.
REQ-012 disp_ready SHALL equal (occupancy < ENTRIES), from registered state only; no same-cycle free-for-dispatch bypass.
REQ-013 On dispatch, data SHALL be written to the lowest-index invalid slot, valid set next edge.
REQ-014 On every edge with cdb_valid, each valid slot with qj==cdb_tag (nonzero) SHALL load vj=cdb_data, qj=0; same for qk/vk.
REQ-015 Dispatch SHALL bypass the CDB: if cdb_valid and disp_qj==cdb_tag (nonzero), slot stores vj=cdb_data, qj=0; same for k.
REQ-016 A slot SHALL be ready when valid, qj==0 and qk==0, evaluated on registered state (CDB capture makes slot ready the following cycle).
REQ-017 Internal alu_busy flag SHALL be set on issue and cleared on alu_done.
REQ-018 Issue SHALL occur when some slot is ready and (alu_busy==0 or alu_done==1); lowest-index ready slot wins.
REQ-019 On issue edge: alu_start<=1 for exactly one cycle; alu_opcode/op1/op2/dest_tag<=slot contents; slot valid cleared.
REQ-020 alu_op1/op2/opcode/dest_tag SHALL hold their last values when alu_start is low.
REQ-021 At most one issue and one dispatch per cycle; both in same cycle SHALL update occupancy by net 0.
REQ-022 Freed slot SHALL be dispatchable from the following cycle.
REQ-023 Back-to-back: with ALU taking start at cycle N and done at N+2, next issue SHALL assert alu_start at N+2 (edge where done is high).
REQ-024 cdb_tag==0 with cdb_valid SHALL match no slot.
REQ-025 alu_done while alu_busy==0 SHALL be ignored.
REQ-026 Dispatch with disp_valid high and disp_ready low SHALL not alter any slot.

Reset
REQ-027 rst_n low SHALL immediately clear all slot valid bits, alu_busy, alu_start, occupancy, alu_opcode, alu_op1, alu_op2, alu_dest_tag to 0; disp_ready=1.
REQ-028 Reset mid-operation SHALL drop all pending slots and any in-flight issue; a late alu_done after reset is ignored per REQ-025.
REQ-029 First dispatch SHALL be accepted on the first rising edge after rst_n deasserts.

Verification
REQ-030 Ready dispatch: opcode=0 (ADD), qj=qk=0, vj=5, vk=7, tag=3 -> alu_start one cycle later with op1=5, op2=7, alu_dest_tag=3; occupancy 1 then 0.
REQ-031 Wakeup: dispatch qj=9, vk=2; hold 3 cycles, no start; cdb_valid tag=9 data=10 -> alu_start next cycle with op1=10, op2=2.
REQ-032 Bypass: dispatch qk=4 in same cycle as cdb_valid tag=4 data=0x55 -> slot issues with op2=0x55, no further wait.
REQ-033 Full: dispatch 4 entries all waiting on tag 7 -> disp_ready=0, occupancy=4, 5th dispatch ignored; CDB tag 7 -> issues in slot order 0,1,2,3 spaced by alu_done, disp_ready=1 after first issue.
REQ-034 Back-to-back: two ready entries, ALU model done 2 cycles after start -> alu_start at cycles N and N+2, never while busy without done.
REQ-035 Reset mid-run: assert rst_n low with 3 pending slots and ALU busy -> all outputs 0, occupancy=0; stray alu_done after release causes no start.
